// File: rtl/udp_payload_buf.sv
// Ping-pong payload buffer between a byte producer and a UDP sender.
// Two banks alternate: one fills while the other is handed to the sender.
module udp_payload_buf #(
  parameter int unsigned MAX_LEN = 1472,
  parameter int unsigned ADDR_W  = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_wr_data,
  input  logic        i_wr_en,
  input  logic        i_wr_last,
  output logic        o_wr_ready,
  output logic        o_enable,
  input  logic        i_ready,
  output logic [15:0] o_data_len,
  input  logic        i_rd,
  output logic [7:0]  o_data,
  output logic        o_drop,
  output logic        o_underrun
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {R_IDLE, R_START, R_WAIT_BUSY, R_BUSY} rd_state_e;

  logic [7:0]             mem_q [DEPTH];
  logic                   mem_we;
  logic [ADDR_W:0]        wr_addr;
  logic [ADDR_W:0]        rd_addr;

  rd_state_e              state_q, state_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [LEN_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [1:0]             full_q, full_d;
  logic [1:0][LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]       data_len_q, data_len_d;
  logic [7:0]             data_q, data_d;
  logic                   drop_q, drop_d;
  logic                   underrun_q, underrun_d;
  logic                   enable_q, wr_ready_q;

  assign wr_addr = {wr_bank_q, wr_cnt_q[ADDR_W-1:0]};
  assign rd_addr = {rd_bank_d, idx_d[ADDR_W-1:0]};

  // Payload storage; contents are never reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr] <= i_wr_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= R_IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      idx_q      <= '0;
      full_q     <= '0;
      len_q      <= '0;
      data_len_q <= '0;
      data_q     <= '0;
      drop_q     <= 1'b0;
      underrun_q <= 1'b0;
      enable_q   <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      idx_q      <= idx_d;
      full_q     <= full_d;
      len_q      <= len_d;
      data_len_q <= data_len_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
      underrun_q <= underrun_d;
      enable_q   <= (state_d == R_START);
      wr_ready_q <= ~full_d[wr_bank_d];
    end
  end

  // Write side and read FSM share the full flags, so both live in one process
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_cnt_d   = wr_cnt_q;
    idx_d      = idx_q;
    full_d     = full_q;
    len_d      = len_q;
    data_len_d = data_len_q;
    drop_d     = 1'b0;
    underrun_d = 1'b0;
    mem_we     = 1'b0;

    if (i_wr_en) begin
      if (full_q[wr_bank_q]) begin
        drop_d = 1'b1;
      end else begin
        if (wr_cnt_q < MAX_LEN_L) mem_we = 1'b1;
        else                      drop_d = 1'b1;
        if (i_wr_last) begin
          len_d[wr_bank_q]  = (wr_cnt_q < MAX_LEN_L) ? wr_cnt_q + 16'd1 : MAX_LEN_L;
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          wr_cnt_d          = '0;
        end else if (wr_cnt_q < MAX_LEN_L) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
      end
    end

    case (state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q] && i_ready) begin
          state_d    = R_START;
          data_len_d = len_q[rd_bank_q];
        end
      end
      R_START: state_d = R_WAIT_BUSY;
      R_WAIT_BUSY: begin
        if (!i_ready) state_d = R_BUSY;
      end
      R_BUSY: begin
        if (i_rd) begin
          if (idx_q < data_len_q) idx_d = idx_q + 16'd1;
          else                    underrun_d = 1'b1;
        end
        // Sender back to idle: release the bank to the writer
        if (i_ready) begin
          state_d           = R_IDLE;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          idx_d             = '0;
        end
      end
      default: state_d = R_IDLE;
    endcase

    // Prefetch next byte so o_data is valid without a request
    data_d = (idx_d < len_q[rd_bank_d]) ? mem_q[rd_addr] : 8'h00;
  end

  assign o_wr_ready = wr_ready_q;
  assign o_enable   = enable_q;
  assign o_data_len = data_len_q;
  assign o_data     = data_q;
  assign o_drop     = drop_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_udp_payload_buf.sv
// Directed bench for udp_payload_buf: ping-pong fill, send, overflow,
// underrun, reset mid-send and simultaneous close/release.
module tb_udp_payload_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_wr_data;
  logic        i_wr_en;
  logic        i_wr_last;
  logic        o_wr_ready;
  logic        o_enable;
  logic        i_ready;
  logic [15:0] o_data_len;
  logic        i_rd;
  logic [7:0]  o_data;
  logic        o_drop;
  logic        o_underrun;

  int n_total = 0;
  int n_pass  = 0;
  int drop_cnt = 0;

  udp_payload_buf #(.MAX_LEN(1472), .ADDR_W(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wr_data  (i_wr_data),
    .i_wr_en    (i_wr_en),
    .i_wr_last  (i_wr_last),
    .o_wr_ready (o_wr_ready),
    .o_enable   (o_enable),
    .i_ready    (i_ready),
    .o_data_len (o_data_len),
    .i_rd       (i_rd),
    .o_data     (o_data),
    .o_drop     (o_drop),
    .o_underrun (o_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (o_drop) drop_cnt++;
  endtask

  task automatic wr(input logic [7:0] d, input logic last);
    i_wr_en   = 1'b1;
    i_wr_data = d;
    i_wr_last = last;
    tick();
    i_wr_en   = 1'b0;
    i_wr_last = 1'b0;
  endtask

  task automatic wr_pkt(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) wr(8'(base + 8'(k)), (k == n - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Raise ready, wait for the start pulse, then take the bus into R_BUSY
  task automatic start_send(input int exp_len);
    logic got;
    got = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_enable) begin
        got = 1'b1;
        break;
      end
    end
    chk("enable_seen", 32'(got), 1);
    chk("data_len", 32'(o_data_len), 32'(exp_len));
    i_ready = 1'b0;
    tick();
    chk("enable_one_cycle", 32'(o_enable), 0);
    tick();
  endtask

  task automatic send(input int len, input int n_rd, input logic [7:0] base);
    start_send(len);
    for (int k = 0; k < n_rd; k++) begin
      if (k < len) chk("rd_data", 32'(o_data), 32'(8'(base + 8'(k))));
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
      if (k >= len) begin
        chk("underrun", 32'(o_underrun), 1);
        chk("underrun_data", 32'(o_data), 0);
      end else begin
        chk("no_underrun", 32'(o_underrun), 0);
      end
    end
    chk("len_stable", 32'(o_data_len), 32'(len));
    i_ready = 1'b1;
    tick();
  endtask

  initial begin
    i_wr_data = '0;
    i_wr_en   = 1'b0;
    i_wr_last = 1'b0;
    i_ready   = 1'b0;
    i_rd      = 1'b0;
    do_reset();
    chk("rst_enable", 32'(o_enable), 0);
    chk("rst_wr_ready", 32'(o_wr_ready), 1);
    chk("rst_len", 32'(o_data_len), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_drop", 32'(o_drop), 0);
    chk("rst_underrun", 32'(o_underrun), 0);

    // 18-byte packet, sent and read back in order
    i_ready = 1'b1;
    wr_pkt(18, 8'h00);
    send(18, 18, 8'h00);

    // Both banks filled while the sender is busy
    do_reset();
    i_ready = 1'b0;
    wr_pkt(4, 8'hA0);
    chk("one_bank_ready", 32'(o_wr_ready), 1);
    wr_pkt(6, 8'hB0);
    chk("both_full_ready", 32'(o_wr_ready), 0);
    wr(8'hCC, 1'b0);
    chk("drop_when_full", 32'(o_drop), 1);
    send(4, 4, 8'hA0);
    chk("ready_after_release", 32'(o_wr_ready), 1);
    send(6, 6, 8'hB0);

    // Overlong packet truncated to MAX_LEN
    do_reset();
    drop_cnt = 0;
    for (int k = 0; k < 1500; k++) wr(8'(k), 1'b0);
    wr(8'hFF, 1'b1);
    chk("overflow_drops", 32'(drop_cnt), 29);
    send(1472, 1472, 8'h00);

    // Reading past the end of a 5-byte packet
    do_reset();
    wr_pkt(5, 8'h50);
    send(5, 6, 8'h50);

    // Reset in the middle of a send
    do_reset();
    wr_pkt(4, 8'h60);
    start_send(4);
    for (int k = 0; k < 3; k++) begin
      chk("pre_rst_data", 32'(o_data), 32'(8'(8'h60 + 8'(k))));
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_enable", 32'(o_enable), 0);
    chk("mid_rst_wr_ready", 32'(o_wr_ready), 1);
    chk("mid_rst_len", 32'(o_data_len), 0);
    chk("mid_rst_data", 32'(o_data), 0);
    wr_pkt(2, 8'h70);
    send(2, 2, 8'h70);

    // Bank 1 closes in the same cycle bank 0 is released
    do_reset();
    wr_pkt(3, 8'h80);
    start_send(3);
    wr(8'h90, 1'b0);
    wr(8'h91, 1'b0);
    i_ready = 1'b1;
    wr(8'h92, 1'b1);
    chk("sim_wr_ready", 32'(o_wr_ready), 1);
    chk("sim_no_drop", 32'(o_drop), 0);
    send(3, 3, 8'h90);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
